// File: rtl/match_pkg.sv
// match_pkg: shared state encoding, widths and health arbitration for match_controller
package match_pkg;
  localparam int SEC_W = 8;
  localparam int WIN_W = 2;
  localparam int MAX_PLAYERS = 4;
  localparam int MAX_HEALTH_W = 16;
  typedef enum logic [2:0] {
    TITLE      = 3'd0,
    COUNTDOWN  = 3'd1,
    FIGHT      = 3'd2,
    KO_HOLD    = 3'd3,
    MATCH_OVER = 3'd4
  } state_t;
  typedef struct packed {
    logic [1:0] idx;
    logic       tie;
  } pick_t;
  function automatic pick_t argmax_health(
    input logic [MAX_PLAYERS*MAX_HEALTH_W-1:0] health,
    input logic [MAX_PLAYERS-1:0]              alive
  );
    pick_t p;
    logic [MAX_HEALTH_W-1:0] best;
    logic [MAX_HEALTH_W-1:0] h;
    logic found;
    p = '{idx: 2'd0, tie: 1'b1};
    best = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_PLAYERS; i++) begin
      h = health[i*MAX_HEALTH_W +: MAX_HEALTH_W];
      if (alive[i] && (!found || h > best)) begin
        best = h;
        p.idx = 2'(i);
        p.tie = 1'b0;
        found = 1'b1;
      end else if (alive[i] && h == best) begin
        p.tie = 1'b1;
      end
    end
    return p;
  endfunction
endpackage

// File: rtl/match_controller_if.sv
// match_controller_if: SoC/health inputs and sequencer outputs of match_controller
interface match_controller_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int HEALTH_W = 10
);
  import match_pkg::*;
  localparam int IDX_W = NUM_PLAYERS > 1 ? $clog2(NUM_PLAYERS) : 1;
  logic                         frame_vs;
  logic [31:0]                  keycodes;
  logic [2:0]                   game_mode;
  logic [NUM_PLAYERS-1:0]       lose;
  logic [NUM_PLAYERS*HEALTH_W-1:0] health;
  logic [2:0]                   state;
  logic                         fight_en;
  logic                         round_rst;
  logic [SEC_W-1:0]             timer_sec;
  logic [IDX_W-1:0]             round_winner;
  logic                         round_draw;
  logic [NUM_PLAYERS*WIN_W-1:0] wins;
  logic [IDX_W-1:0]             match_winner;
  logic [8:0]                   anim_count;
  modport master (
    output frame_vs, keycodes, game_mode, lose, health,
    input  state, fight_en, round_rst, timer_sec, round_winner, round_draw, wins, match_winner, anim_count
  );
  modport slave (
    input  frame_vs, keycodes, game_mode, lose, health,
    output state, fight_en, round_rst, timer_sec, round_winner, round_draw, wins, match_winner, anim_count
  );
endinterface

// File: rtl/frame_timer.sv
// frame_timer: frame tick edge detect, per-second frame divider and seconds down counter
module frame_timer
  import match_pkg::*;
#(
  parameter int FRAMES_PER_SEC = 60,
  parameter int RESET_SEC = 99
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             frame_vs,
  input  logic             en,
  input  logic             load,
  input  logic [SEC_W-1:0] load_val,
  output logic             tick,
  output logic [SEC_W-1:0] sec,
  output logic             zero,
  output logic             expire
);
  localparam int FC_W = FRAMES_PER_SEC > 1 ? $clog2(FRAMES_PER_SEC) : 1;
  logic            vs_q;
  logic [FC_W-1:0] frame_cnt;
  logic            wrap;
  assign wrap = en && tick && frame_cnt == FC_W'(FRAMES_PER_SEC - 1);
  assign zero = sec == '0;
  assign expire = wrap && sec == SEC_W'(1);
  always_ff @(posedge Clk) begin
    if (Reset) begin
      vs_q <= 1'b1;
      tick <= 1'b0;
      frame_cnt <= '0;
      sec <= SEC_W'(RESET_SEC);
    end else begin
      vs_q <= frame_vs;
      tick <= frame_vs & ~vs_q;
      frame_cnt <= load ? '0 : (en && tick) ? (wrap ? '0 : frame_cnt + FC_W'(1)) : frame_cnt;
      sec <= load ? load_val : (wrap && !zero) ? sec - SEC_W'(1) : sec;
    end
  end
endmodule

// File: rtl/match_controller.sv
// match_controller: round/match sequencer driving fight enable, round reset and scoring
module match_controller
  import match_pkg::*;
#(
  parameter int         NUM_PLAYERS = 2,
  parameter int         HEALTH_W = 10,
  parameter int         ROUNDS_TO_WIN = 2,
  parameter int         ROUND_SECONDS = 99,
  parameter int         FRAMES_PER_SEC = 60,
  parameter int         COUNTDOWN_SECONDS = 3,
  parameter int         KO_HOLD_FRAMES = 120,
  parameter logic [7:0] START_KEY = 8'h28,
  parameter logic [7:0] RESTART_KEY = 8'h15
) (
  input logic               Clk,
  input logic               Reset,
  match_controller_if.slave bus
);
  localparam int IDX_W = NUM_PLAYERS > 1 ? $clog2(NUM_PLAYERS) : 1;
  state_t                               st;
  logic                                 fight_en;
  logic                                 round_rst;
  logic                                 round_draw;
  logic [IDX_W-1:0]                     round_winner;
  logic [IDX_W-1:0]                     match_winner;
  logic [IDX_W-1:0]                     best_idx;
  logic [IDX_W-1:0]                     match_idx;
  logic [NUM_PLAYERS-1:0][WIN_W-1:0]    wins;
  logic [8:0]                           anim_count;
  logic [MAX_PLAYERS*MAX_HEALTH_W-1:0]  hpad;
  logic [MAX_PLAYERS-1:0]               alive;
  pick_t                                best;
  logic                                 start;
  logic                                 restart;
  logic                                 begin_match;
  logic                                 match_hit;
  logic                                 to_title;
  logic                                 hold_done;
  logic                                 anim_inc;
  logic                                 t_load;
  logic                                 tick;
  logic                                 zero;
  logic                                 expire;
  logic [SEC_W-1:0]                     t_val;
  logic [SEC_W-1:0]                     timer_sec;
  always_comb begin
    hpad = '0;
    alive = '0;
    start = 1'b0;
    restart = 1'b0;
    match_hit = 1'b0;
    match_idx = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      hpad[i*MAX_HEALTH_W +: MAX_HEALTH_W] = MAX_HEALTH_W'(bus.health[i*HEALTH_W +: HEALTH_W]);
      alive[i] = ~bus.lose[i];
      if (wins[i] == WIN_W'(ROUNDS_TO_WIN)) begin
        match_hit = 1'b1;
        match_idx = IDX_W'(i);
      end
    end
    for (int i = 0; i < 4; i++) begin
      start |= bus.keycodes[i*8 +: 8] == START_KEY;
      restart |= bus.keycodes[i*8 +: 8] == RESTART_KEY;
    end
  end
  assign best = argmax_health(hpad, alive);
  assign best_idx = IDX_W'(best.idx);
  assign begin_match = start && bus.game_mode != 3'b000;
  assign anim_inc = tick && anim_count != '1;
  assign hold_done = tick && anim_count == 9'(KO_HOLD_FRAMES - 1);
  assign to_title = (st != TITLE && bus.game_mode == 3'b000) || (st == MATCH_OVER && restart);
  assign t_load = to_title || (st == TITLE && begin_match) || (st == COUNTDOWN && expire)
                  || (st == KO_HOLD && hold_done && !match_hit);
  assign t_val = (to_title || st == COUNTDOWN) ? SEC_W'(ROUND_SECONDS) : SEC_W'(COUNTDOWN_SECONDS);
  frame_timer #(
    .FRAMES_PER_SEC(FRAMES_PER_SEC),
    .RESET_SEC(ROUND_SECONDS)
  ) u_timer (
    .Clk(Clk),
    .Reset(Reset),
    .frame_vs(bus.frame_vs),
    .en(st == COUNTDOWN || st == FIGHT),
    .load(t_load),
    .load_val(t_val),
    .tick(tick),
    .sec(timer_sec),
    .zero(zero),
    .expire(expire)
  );
  always_ff @(posedge Clk) begin
    round_rst <= 1'b0;
    fight_en <= 1'b0;
    if (Reset) begin
      st <= TITLE;
      wins <= '0;
      round_winner <= '0;
      round_draw <= 1'b0;
      match_winner <= '0;
      anim_count <= '0;
    end else if (to_title) begin
      st <= TITLE;
    end else begin
      case (st)
        TITLE: if (begin_match) begin
          wins <= '0;
          round_rst <= 1'b1;
          st <= COUNTDOWN;
        end
        COUNTDOWN: if (expire) begin
          fight_en <= 1'b1;
          st <= FIGHT;
        end
        FIGHT: if (|bus.lose || zero) begin
          round_winner <= best_idx;
          round_draw <= best.tie;
          if (!best.tie) wins[best_idx] <= wins[best_idx] + WIN_W'(~&wins[best_idx]);
          anim_count <= '0;
          st <= KO_HOLD;
        end else begin
          fight_en <= 1'b1;
        end
        KO_HOLD: begin
          if (anim_inc) anim_count <= anim_count + 9'd1;
          if (hold_done && match_hit) begin
            match_winner <= match_idx;
            anim_count <= '0;
            st <= MATCH_OVER;
          end else if (hold_done) begin
            round_rst <= 1'b1;
            st <= COUNTDOWN;
          end
        end
        MATCH_OVER: if (anim_inc) anim_count <= anim_count + 9'd1;
        default: st <= TITLE;
      endcase
    end
  end
  assign bus.state = st;
  assign bus.fight_en = fight_en;
  assign bus.round_rst = round_rst;
  assign bus.timer_sec = timer_sec;
  assign bus.round_winner = round_winner;
  assign bus.round_draw = round_draw;
  assign bus.wins = wins;
  assign bus.match_winner = match_winner;
  assign bus.anim_count = anim_count;
endmodule

// File: tb/tb_match_controller.sv
// tb_match_controller: table, directed and random round checks of match_controller against a round-outcome model
module tb_match_controller;
  localparam int NP = 2;
  localparam int HW = 10;
  localparam logic [31:0] KEY_START = 32'h0000_2800;
  localparam logic [31:0] KEY_RESTART = 32'h0000_0015;
  typedef struct {
    logic [1:0] lose;
    int         h0;
    int         h1;
    int         win;
    bit         draw;
  } vec_t;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   rst_pulses = 0;
  int   dbl = 0;
  logic prev_rst = 1'b0;
  int   wins_m[NP];
  vec_t vecs[6];
  match_controller_if #(.NUM_PLAYERS(NP), .HEALTH_W(HW)) bus ();
  match_controller #(
    .NUM_PLAYERS(NP),
    .HEALTH_W(HW),
    .ROUNDS_TO_WIN(2),
    .ROUND_SECONDS(5),
    .FRAMES_PER_SEC(4),
    .COUNTDOWN_SECONDS(2),
    .KO_HOLD_FRAMES(3),
    .START_KEY(8'h28),
    .RESTART_KEY(8'h15)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .bus(bus)
  );
  always #5 Clk = ~Clk;
  always @(negedge Clk) begin
    if (bus.round_rst) begin
      rst_pulses++;
      if (prev_rst) dbl++;
    end
    prev_rst = bus.round_rst;
  end
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask
  task automatic tick();
    bus.frame_vs = 1'b1;
    step(3);
    bus.frame_vs = 1'b0;
    step(3);
  endtask
  task automatic ticks(input int n);
    repeat (n) tick();
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask
  function automatic int wins_packed();
    return wins_m[1] * 4 + wins_m[0];
  endfunction
  function automatic void ref_round(input logic [1:0] l, input int h0, input int h1, output int w, output bit d);
    int hp[NP];
    int surv[$];
    hp[0] = h0;
    hp[1] = h1;
    for (int i = 0; i < NP; i++) if (!l[i]) surv.push_back(i);
    d = 1'b1;
    w = 0;
    if (surv.size() == 1) begin
      d = 1'b0;
      w = surv[0];
    end else if (surv.size() == 2) begin
      d = hp[surv[0]] == hp[surv[1]];
      w = hp[surv[1]] > hp[surv[0]] ? surv[1] : surv[0];
    end
  endfunction
  task automatic goto_fight();
    bus.keycodes = KEY_START;
    step(1);
    bus.keycodes = '0;
    chk("start_state", bus.state, 1);
    wins_m = '{0, 0};
    chk("start_wins", bus.wins, 0);
    ticks(8);
    chk("fight_state", bus.state, 2);
    chk("fight_timer", bus.timer_sec, 5);
  endtask
  task automatic leave_ko();
    int p;
    p = rst_pulses;
    ticks(3);
    if (wins_m[0] == 2 || wins_m[1] == 2) begin
      chk("over_state", bus.state, 4);
      chk("match_winner", bus.match_winner, wins_m[1] == 2 ? 1 : 0);
      chk("over_anim_0", bus.anim_count, 0);
      tick();
      chk("over_anim_1", bus.anim_count, 1);
      tick();
      chk("over_anim_2", bus.anim_count, 2);
      bus.keycodes = KEY_RESTART;
      step(1);
      bus.keycodes = '0;
      chk("restart_state", bus.state, 0);
      chk("wins_kept", bus.wins, wins_packed());
      goto_fight();
    end else begin
      chk("next_state", bus.state, 1);
      chk("round_rst_pulse", rst_pulses, p + 1);
      chk("next_timer", bus.timer_sec, 2);
      ticks(8);
      chk("refight_state", bus.state, 2);
    end
  endtask
  task automatic play_round(input logic [1:0] l, input int h0, input int h1, input int w, input bit d);
    bus.health = {HW'(h1), HW'(h0)};
    if (l == 2'b00) begin
      ticks(19);
      chk("pre_timeout_state", bus.state, 2);
      chk("pre_timeout_timer", bus.timer_sec, 1);
      tick();
    end else begin
      bus.lose = l;
      step(1);
      bus.lose = '0;
    end
    chk("ko_state", bus.state, 3);
    chk("ko_fight_en", bus.fight_en, 0);
    chk("round_draw", bus.round_draw, d);
    if (!d) begin
      chk("round_winner", bus.round_winner, w);
      if (wins_m[w] < 3) wins_m[w]++;
    end
    chk("wins", bus.wins, wins_packed());
    leave_ko();
  endtask
  initial begin
    int w;
    bit d;
    int p;
    logic [1:0] l;
    int h0;
    int h1;
    bus.frame_vs = 1'b0;
    bus.keycodes = '0;
    bus.game_mode = 3'd1;
    bus.lose = '0;
    bus.health = '0;
    wins_m = '{0, 0};
    vecs[0] = '{2'b00, 300, 450, 1, 1'b0};
    vecs[1] = '{2'b00, 400, 400, 0, 1'b1};
    vecs[2] = '{2'b01, 300, 450, 1, 1'b0};
    vecs[3] = '{2'b10, 100, 200, 0, 1'b0};
    vecs[4] = '{2'b11, 300, 450, 0, 1'b1};
    vecs[5] = '{2'b00, 450, 300, 0, 1'b0};
    step(3);
    chk("rst_state", bus.state, 0);
    chk("rst_timer", bus.timer_sec, 5);
    chk("rst_fight_en", bus.fight_en, 0);
    chk("rst_round_rst", bus.round_rst, 0);
    chk("rst_wins", bus.wins, 0);
    chk("rst_anim", bus.anim_count, 0);
    Reset = 1'b0;
    step(2);
    chk("title_idle", bus.state, 0);
    bus.keycodes = KEY_START;
    step(1);
    bus.keycodes = '0;
    chk("start_rst_hi", bus.round_rst, 1);
    chk("start_cd_state", bus.state, 1);
    chk("start_cd_timer", bus.timer_sec, 2);
    step(1);
    chk("start_rst_lo", bus.round_rst, 0);
    ticks(7);
    chk("cd_7_state", bus.state, 1);
    chk("cd_7_timer", bus.timer_sec, 1);
    tick();
    chk("cd_8_state", bus.state, 2);
    chk("cd_8_timer", bus.timer_sec, 5);
    chk("cd_8_fight_en", bus.fight_en, 1);
    play_round(2'b10, 500, 500, 0, 1'b0);
    play_round(2'b10, 500, 500, 0, 1'b0);
    for (int i = 0; i < 6; i++) play_round(vecs[i].lose, vecs[i].h0, vecs[i].h1, vecs[i].win, vecs[i].draw);
    bus.health = {HW'(300), HW'(450)};
    ticks(19);
    bus.frame_vs = 1'b1;
    step(2);
    chk("same_cycle_zero", bus.timer_sec, 0);
    chk("same_cycle_fight", bus.state, 2);
    bus.lose = 2'b11;
    step(1);
    bus.lose = '0;
    bus.frame_vs = 1'b0;
    chk("same_cycle_ko", bus.state, 3);
    chk("same_cycle_draw", bus.round_draw, 1);
    chk("same_cycle_wins", bus.wins, wins_packed());
    step(2);
    leave_ko();
    for (int i = 0; i < 16; i++) begin
      l = 2'($urandom_range(0, 3));
      h0 = $urandom_range(1, 4) * 100;
      h1 = $urandom_range(1, 4) * 100;
      ref_round(l, h0, h1, w, d);
      play_round(l, h0, h1, w, d);
    end
    p = rst_pulses;
    bus.game_mode = 3'd0;
    step(1);
    chk("mode0_state", bus.state, 0);
    chk("mode0_fight_en", bus.fight_en, 0);
    bus.game_mode = 3'd1;
    step(2);
    chk("mode0_stay", bus.state, 0);
    chk("mode0_no_rst", rst_pulses, p);
    goto_fight();
    play_round(2'b01, 300, 300, 1, 1'b0);
    chk("pre_reset_wins", bus.wins, 4);
    bus.frame_vs = 1'b1;
    Reset = 1'b1;
    step(1);
    chk("midrst_state", bus.state, 0);
    chk("midrst_wins", bus.wins, 0);
    chk("midrst_fight_en", bus.fight_en, 0);
    chk("midrst_timer", bus.timer_sec, 5);
    chk("midrst_anim", bus.anim_count, 0);
    step(1);
    Reset = 1'b0;
    bus.keycodes = KEY_START;
    step(1);
    bus.keycodes = '0;
    chk("rel_state", bus.state, 1);
    step(2);
    bus.frame_vs = 1'b0;
    step(2);
    ticks(7);
    chk("no_spurious_tick", bus.state, 1);
    tick();
    chk("rel_fight", bus.state, 2);
    chk("no_double_rst", dbl, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
